// File: rtl/rob_squash_walker_if.sv
// Squash-recovery bus between branch resolve, ROB, map table, free list and the walker.
// master = the walker side, slave = the surrounding pipeline.
interface rob_squash_walker_if #(
  parameter int unsigned ROB_SZ    = 8,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned ARCH_REGS = 32
);
  localparam int unsigned IDX_W  = $clog2(ROB_SZ);
  localparam int unsigned TAG_W  = $clog2(PHYS_REGS);
  localparam int unsigned AREG_W = $clog2(ARCH_REGS);

  logic              squash_en;
  logic [IDX_W-1:0]  squash_rob_idx;
  logic [IDX_W-1:0]  rob_tail_idx;
  logic [IDX_W-1:0]  rob_rd_idx;
  logic [TAG_W-1:0]  rob_rd_t;
  logic [TAG_W-1:0]  rob_rd_t_old;
  logic [AREG_W-1:0] rob_rd_areg;
  logic              rob_rd_has_dest;
  logic              map_restore_en;
  logic [AREG_W-1:0] map_restore_areg;
  logic [TAG_W-1:0]  map_restore_tag;
  logic              fl_return_en;
  logic [TAG_W-1:0]  fl_return_tag;
  logic              rob_set_tail_en;
  logic [IDX_W-1:0]  rob_set_tail_idx;
  logic              stall_dispatch;
  logic              busy;

  modport master (
    input  squash_en, squash_rob_idx, rob_tail_idx,
    input  rob_rd_t, rob_rd_t_old, rob_rd_areg, rob_rd_has_dest,
    output rob_rd_idx, map_restore_en, map_restore_areg, map_restore_tag,
    output fl_return_en, fl_return_tag, rob_set_tail_en, rob_set_tail_idx,
    output stall_dispatch, busy
  );

  modport slave (
    output squash_en, squash_rob_idx, rob_tail_idx,
    output rob_rd_t, rob_rd_t_old, rob_rd_areg, rob_rd_has_dest,
    input  rob_rd_idx, map_restore_en, map_restore_areg, map_restore_tag,
    input  fl_return_en, fl_return_tag, rob_set_tail_en, rob_set_tail_idx,
    input  stall_dispatch, busy
  );
endinterface

// File: rtl/rob_squash_walker.sv
// Branch-mispredict recovery: walks younger ROB entries youngest-first, restoring the
// map table and freeing tags, then rolls the ROB tail back to just past the branch.
module rob_squash_walker #(
  parameter int unsigned ROB_SZ    = 8,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned ARCH_REGS = 32
) (
  input  logic                clock,
  input  logic                reset,
  rob_squash_walker_if.master bus
);
  localparam int unsigned IDX_W  = $clog2(ROB_SZ);
  localparam int unsigned TAG_W  = $clog2(PHYS_REGS);
  localparam int unsigned AREG_W = $clog2(ARCH_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]  stop_idx_q, stop_idx_d;

  logic [IDX_W-1:0]  rd_idx_c;
  logic              restore_en_c;
  logic [AREG_W-1:0] restore_areg_c;
  logic [TAG_W-1:0]  restore_tag_c;
  logic [TAG_W-1:0]  return_tag_c;
  logic              set_tail_en_c;
  logic [IDX_W-1:0]  set_tail_idx_c;
  logic              busy_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_idx_q  <= '0;
      stop_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      stop_idx_q <= stop_idx_d;
    end
  end

  // Next state and the per-cycle walk/rollback outputs.
  always_comb begin
    state_d        = state_q;
    cur_idx_d      = cur_idx_q;
    stop_idx_d     = stop_idx_q;
    rd_idx_c       = '0;
    restore_en_c   = 1'b0;
    restore_areg_c = '0;
    restore_tag_c  = '0;
    return_tag_c   = '0;
    set_tail_en_c  = 1'b0;
    set_tail_idx_c = '0;

    case (state_q)
      IDLE: begin
        if (bus.squash_en) begin
          stop_idx_d = IDX_W'(bus.squash_rob_idx + 1'b1);
          cur_idx_d  = IDX_W'(bus.rob_tail_idx - 1'b1);
          // Tail directly after the branch means nothing younger to undo.
          state_d    = (bus.rob_tail_idx == stop_idx_d) ? DONE : WALK;
        end
      end
      WALK: begin
        rd_idx_c       = cur_idx_q;
        restore_en_c   = bus.rob_rd_has_dest;
        restore_areg_c = bus.rob_rd_areg;
        restore_tag_c  = bus.rob_rd_t_old;
        return_tag_c   = bus.rob_rd_t;
        cur_idx_d      = IDX_W'(cur_idx_q - 1'b1);
        if (cur_idx_q == stop_idx_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        set_tail_en_c  = 1'b1;
        set_tail_idx_c = stop_idx_q;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_c = (state_q != IDLE);

  assign bus.rob_rd_idx       = rd_idx_c;
  assign bus.map_restore_en   = restore_en_c;
  assign bus.map_restore_areg = restore_areg_c;
  assign bus.map_restore_tag  = restore_tag_c;
  assign bus.fl_return_en     = restore_en_c;
  assign bus.fl_return_tag    = return_tag_c;
  assign bus.rob_set_tail_en  = set_tail_en_c;
  assign bus.rob_set_tail_idx = set_tail_idx_c;
  assign bus.busy             = busy_c;
  // Stall already in the resolve cycle so nothing dispatches behind the squash.
  assign bus.stall_dispatch   = bus.squash_en | busy_c;

endmodule
